// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/compare/shift ops, WIDTH-step shift-add multiply
// and restoring divide, with valid/ready handshakes and results held until consumed.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mc_op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q;
  logic               overflow_q, carry_q, zero_q, dbz_q;

  logic               accept, is_mc, last_step;
  logic [WIDTH:0]     sum, diff, mul_sum, div_sh;
  logic [WIDTH-1:0]   div_sub, alu_res, mc_res;
  logic               div_ge, alu_ov, alu_cy, mc_ov, mc_dbz;
  logic [SHW-1:0]     shamt;

  assign accept    = in_valid & in_ready;
  assign is_mc     = &op[3:2];
  assign last_step = (cnt_q == SHW'(WIDTH - 1));
  assign shamt     = b[SHW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = is_mc ? StBusy : StDone;
      StBusy:  if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == StIdle) & ~rst;
    out_valid = (state_q == StDone);
  end

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_cy  = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
        alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff[WIDTH-1:0];
        alu_cy  = diff[WIDTH];
        alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:    alu_res = ~a;
      4'd3:    alu_res = a & b;
      4'd4:    alu_res = a | b;
      4'd5:    alu_res = a ^ b;
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, a == b};
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'd9:    alu_res = a << shamt;
      4'd10:   alu_res = a >> shamt;
      4'd11:   alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL, {remainder, quotient} for DIV.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, b_q});
  assign div_sub = div_sh[WIDTH-1:0] - b_q;

  always_comb begin
    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    if (mc_op_q[1]) begin
      acc_d = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end
  end

  // b == 0 needs no special case: every step subtracts, giving all-ones quotient and rem = a.
  assign mc_res = mc_op_q[0] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
  assign mc_ov  = (mc_op_q == 2'b00) & (|acc_d[2*WIDTH-1:WIDTH]);
  assign mc_dbz = mc_op_q[1] & ~(|b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_op_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else if (accept) begin
      mc_op_q <= op[1:0];
      a_q     <= a;
      b_q     <= b;
      cnt_q   <= '0;
      if (is_mc) begin
        acc_q <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
      end else begin
        result_q   <= alu_res;
        overflow_q <= alu_ov;
        carry_q    <= alu_cy;
        zero_q     <= ~(|alu_res);
        dbz_q      <= 1'b0;
      end
    end else if (state_q == StBusy) begin
      acc_q <= acc_d;
      cnt_q <= last_step ? '0 : cnt_q + SHW'(1);
      if (last_step) begin
        result_q   <= mc_res;
        overflow_q <= mc_ov;
        carry_q    <= 1'b0;
        zero_q     <= ~(|mc_res);
        dbz_q      <= mc_dbz;
      end
    end
  end

  assign result      = result_q;
  assign overflow    = overflow_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU with a valid/ready handshake on both input and output. It extends the combinational 8-op ALU with:
- unsigned compare and shifts (single-cycle);
- iterative multiply and divide (WIDTH-cycle).

It sits between the decode/issue stage and writeback in the NPC datapath. One operation is in flight at a time, and results are held until consumed.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
op  in  4  operation code (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
overflow  out  1  signed overflow (ADD/SUB), product-high-nonzero (MUL)
carry  out  1  carry-out (ADD), borrow (SUB)
zero  out  1  result == 0
div_by_zero  out  1  DIVU/REMU with b == 0

Behaviour:
- op encoding:
  - 0 ADD, 1 SUB, 2 NOT a, 3 AND, 4 OR, 5 XOR.
  - 6 SLT (signed), 7 EQ, 8 SLTU.
  - 9 SLL, 10 SRL, 11 SRA; shift amount is b[SHW-1:0].
  - 12 MUL (low WIDTH bits), 13 MULHU (high WIDTH bits, unsigned).
  - 14 DIVU, 15 REMU.
- SLT/EQ/SLTU return {WIDTH-1 zeros, bit}.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) & ~rst.
- Accept occurs when in_valid & in_ready. Operands and op are registered at accept; later input changes are ignored.
- IDLE transitions:
  - Ops 0-11: go to DONE; out_valid is asserted the cycle after accept (latency 1).
  - Ops 12-15: go to BUSY with a WIDTH-step counter at 0.
- BUSY:
  - MUL/MULHU: one shift-add step per cycle into a 2*WIDTH accumulator.
  - DIVU/REMU: one restoring shift-subtract step per cycle.
  - After WIDTH steps, go to DONE. out_valid rises exactly WIDTH+1 cycles after the accept cycle.
- DONE:
  - out_valid = 1, and result and all flags are held stable until out_ready.
  - On out_valid & out_ready, go to IDLE; out_valid falls the next cycle.
  - A new request can be accepted no earlier than the cycle after the handshake.
- Flags:
  - zero = ~|result for every op.
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit unsigned sum; overflow = (a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
  - SUB: carry = borrow (1 iff a <u b); overflow = (a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]).
  - MUL: overflow = |(high half of unsigned product).
  - All other ops: overflow = carry = 0.
  - div_by_zero = 1 only for ops 14/15 with b==0, else 0.
- Divide by zero:
  - Same WIDTH+1 latency as any other divide.
  - DIVU returns all ones; REMU returns a.
- Reset (rst=1 at a clock edge, any state, including mid-BUSY or DONE while stalled):
  - Next state is IDLE; the in-flight operation is discarded and produces no out_valid.
  - out_valid = 0; result = 0; overflow = carry = zero = div_by_zero = 0; counter = 0.
  - in_ready = 0 while rst is high, 1 in the first cycle after release.
- in_valid asserted during BUSY or DONE: ignored, no accept, no state corruption.
- Shifts of 0 return a unchanged; SRA replicates a[MSB].

Test Plan:
1. WIDTH=8, ADD a=8'h7F b=8'h01 -> result 8'h80, overflow=1, carry=0, zero=0, out_valid exactly 1 cycle after accept. ADD 8'hFF+8'h01 -> 8'h00, carry=1, zero=1.
2. WIDTH=8, compares and shifts:
   - SUB 8'h00-8'h01 -> 8'hFF, carry=1, overflow=0.
   - SLT a=8'hFF b=8'h01 -> 8'h01; SLTU with same operands -> 8'h00.
   - SRA a=8'h80 b=3 -> 8'hF0; SRL with same operands -> 8'h10.
3. WIDTH=8, multiply:
   - MUL 8'h10*8'h10 -> result 8'h00, zero=1, overflow=1; MULHU with same operands -> 8'h01.
   - out_valid exactly 9 cycles after accept; in_ready=0 throughout.
4. WIDTH=8, divide:
   - DIVU 100/7 -> 14, REMU 100/7 -> 2, div_by_zero=0.
   - DIVU 5/0 -> 8'hFF, div_by_zero=1; REMU 5/0 -> 8'h05, div_by_zero=1; both with 9-cycle latency.
5. Backpressure: complete ADD 3+4, hold out_ready=0 for 5 cycles while in_valid=1 with new operands.
   -> result stays 7 and flags are stable; in_ready=0; no new accept.
   -> out_ready=1 gives a handshake; the next request is accepted 1 cycle later.
6. Reset mid-operation: assert rst for 1 cycle on BUSY step 3 of a MUL.
   -> Next cycle IDLE; out_valid never asserts for that MUL; all outputs 0; in_ready=1 after release.
   -> A following ADD 2+2 returns 4 with correct flags.
